switch_allocator_rr: RTL and testbench
======================================

Name: switch_allocator_rr

Overview:
- Separable input-first round-robin switch allocator with per-output-VC credit tracking.
- Each cycle it picks at most one VC per input port, then at most one input per output port.
- Its registered outputs drive the crossbar's per-output input-select, and the pop strobes drive the input buffers.
- Sits between the input blocks (after VC allocation) and the crossbar.

Parameters:
- PORT_NUM, 5, router ports (inputs = outputs).
- VC_NUM, 2, virtual channels per port.
- BUFFER_SIZE, 8, downstream buffer depth per VC (initial credits).

Ports:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- request_i  in  [PORT_NUM][VC_NUM]  VC holds a flit ready to traverse.
- out_port_i  in  [PORT_NUM][VC_NUM] x PORT_SIZE  routed output port per VC.
- downstream_vc_i  in  [PORT_NUM][VC_NUM] x VC_SIZE  allocated downstream VC.
- is_tail_i  in  [PORT_NUM][VC_NUM]  head-of-buffer flit is tail.
- credit_valid_i  in  [PORT_NUM]  credit returned on output port.
- credit_vc_i  in  [PORT_NUM] x VC_SIZE  VC of returned credit.
- vc_grant_o  out  [PORT_NUM][VC_NUM]  one-hot per input: pop this VC.
- input_vc_sel_o  out  [PORT_NUM] x PORT_SIZE  crossbar select, indexed by output.
- valid_sel_o  out  [PORT_NUM]  output carries a valid flit this cycle.
- credit_count_o  out  [PORT_NUM][VC_NUM] x CREDIT_SIZE  debug view of counters.

Behaviour:
- Reset: all grants 0, input_vc_sel_o 0, valid_sel_o 0, credits = BUFFER_SIZE, all RR pointers 0.
- A VC is eligible when request_i=1 and credit[out_port_i][downstream_vc_i] > 0.
- Stage 1, per input: round-robin over eligible VCs starting at ptr_in[ip]. Produces one candidate and its requested output.
- Stage 2, per output: round-robin over inputs whose candidate targets it, starting at ptr_out[op].
- Winners are registered: vc_grant_o, input_vc_sel_o and valid_sel_o are valid 1 cycle after request_i.
- Losers drop out for that cycle and retry; no pop happens.
- Pointers update only on a final grant:
  - ptr_in = granted VC + 1, wrapping modulo VC_NUM.
  - ptr_out = granted input + 1, wrapping modulo PORT_NUM.
  - A stage-1 winner that loses stage 2 leaves ptr_in unchanged.
- Credits:
  - A final grant decrements credit[op][dvc].
  - credit_valid_i increments credit[op][credit_vc_i].
  - Same-cycle decrement and increment on one counter leaves it unchanged.
  - Counters saturate: no decrement at 0 (excluded by eligibility); an increment at BUFFER_SIZE is ignored.
  - A credit returned in cycle N makes the VC eligible in cycle N+1, never the same cycle.
- No output is granted to more than one input; no input gets more than one VC granted.
- Port turnaround (out_port_i == own input index) is allowed; no special case.
- No requests: valid_sel_o=0, vc_grant_o=0, input_vc_sel_o holds its last value.
- Reset asserted mid-operation clears all state immediately, with no stale grant on the first cycle after deassert.

Optional Feature:
- Macro: SA_PACKET_LOCK_EN.
- Defined:
  - Once an output is granted to (input, VC) for a non-tail flit, it stays locked to that pair until that pair's tail flit is granted.
  - While locked, the output ignores other inputs and that input's other VCs are masked.
  - ptr_out advances only when the lock releases.
  - A lock held while credits are 0 stalls the output.
- Undefined: per-flit arbitration; is_tail_i is unused.

Decomposition:
- noc_params holds: PORT_NUM, VC_NUM, BUFFER_SIZE, PORT_SIZE=$clog2(PORT_NUM), VC_SIZE=$clog2(VC_NUM), CREDIT_SIZE=$clog2(BUFFER_SIZE+1), and port enum (LOCAL, NORTH, SOUTH, WEST, EAST).
- Sub-module rr_arbiter #(N):
  - request vector plus pointer in, one-hot grant plus index out, combinational.
  - Instantiated PORT_NUM times for stage 1 (N=VC_NUM) and PORT_NUM times for stage 2 (N=PORT_NUM).
- Pointer and credit registers stay in the top.

Test Plan:
- Reset, then idle: all outputs 0; every credit_count_o = 8.
- Input 1 VC0 and input 3 VC1 both request output 2, ptr 0, for 4 cycles → grants alternate 1,3,1,3 via input_vc_sel_o[2]; valid_sel_o[2]=1 each cycle; credit[2][dvc] falls by 4.
- Input 0 VC0 requests output 4 with 8 grants and no credit return → 8 grants, then valid_sel_o[4]=0. A credit returned in cycle N produces a grant visible in cycle N+2.
- Same-cycle grant and credit return on output 1, VC1 at count 5 → count stays 5.
- Input 2 has both VCs requesting different free outputs → only one VC granted per cycle, alternating VC0, VC1.
- SA_PACKET_LOCK_EN: input 1 holds a 3-flit packet to output 0 while input 4 competes → output 0 serves input 1 for 3 cycles, then input 4.

Source files
------------

// File: rtl/switch_allocator_rr_pkg.sv
// -----------------------------------------------------------------------------
// noc_params
//   Shared router parameters for the switch allocator slice: port and VC
//   counts, downstream buffer depth, the derived index/counter widths, the
//   port-name enum and a small wrap-around increment helper.
//   To build a different router size, change the values here.
// -----------------------------------------------------------------------------
package noc_params;

  localparam int PORT_NUM    = 5;
  localparam int VC_NUM      = 2;
  localparam int BUFFER_SIZE = 8;

  localparam int PORT_SIZE   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int VC_SIZE     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int CREDIT_SIZE = $clog2(BUFFER_SIZE + 1);

  typedef enum logic [PORT_SIZE-1:0] {
    LOCAL,
    NORTH,
    SOUTH,
    WEST,
    EAST
  } port_t;

  // Next round-robin position after idx, wrapping at n.
  function automatic int wrap_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. The requester at index ptr has the
//   highest priority, then ptr+1 and so on, wrapping back to 0.
//
// Ports:
//   request     in  [N]      one bit per requester
//   ptr         in  [IDX_W]  index of the highest-priority requester
//   grant       out [N]      one-hot grant (all zero when nothing requests)
//   grant_idx   out [IDX_W]  binary index of the granted requester
//   grant_valid out 1        some requester was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     request,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // Two priority passes instead of a rotate: the first pass only considers
  // requesters at or above ptr, the second falls back to the lowest index
  // overall, which covers the wrapped-around part of the ring. Keeping all
  // indices loop constants avoids variable-index rotation logic.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!grant_valid && request[i] && (IDX_W'(i) >= ptr)) begin
        grant[i]    = 1'b1;
        grant_idx   = IDX_W'(i);
        grant_valid = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!grant_valid && request[i]) begin
        grant[i]    = 1'b1;
        grant_idx   = IDX_W'(i);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator_rr.sv
// -----------------------------------------------------------------------------
// switch_allocator_rr
//   Separable input-first round-robin switch allocator with per-output-VC
//   credit counters. Stage 1 picks one eligible VC per input, stage 2 picks
//   one input per output. Winners are registered and drive the crossbar
//   select and the input-buffer pop strobes one cycle after the request.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   request_i         [PORT_NUM][VC_NUM]  VC has a flit ready
//   out_port_i        per VC routed output port
//   downstream_vc_i   per VC allocated downstream VC
//   is_tail_i         per VC head flit is a tail (packet lock build only)
//   credit_valid_i    [PORT_NUM] credit returned on an output port
//   credit_vc_i       [PORT_NUM] VC of the returned credit
//   vc_grant_o        per input one-hot pop strobe
//   input_vc_sel_o    per output crossbar input select (holds when idle)
//   valid_sel_o       per output a flit crosses this cycle
//   credit_count_o    per output VC credit counters (debug)
//
// Build option:
//   SA_PACKET_LOCK_EN  when defined, an output granted to a non-tail flit
//                      stays locked to that (input, VC) until its tail
//                      is granted.
// -----------------------------------------------------------------------------
import noc_params::*;

module switch_allocator_rr (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]               request_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]  downstream_vc_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]               is_tail_i,
  input  logic [PORT_NUM-1:0]                           credit_valid_i,
  input  logic [PORT_NUM-1:0][VC_SIZE-1:0]              credit_vc_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]               vc_grant_o,
  output logic [PORT_NUM-1:0][PORT_SIZE-1:0]            input_vc_sel_o,
  output logic [PORT_NUM-1:0]                           valid_sel_o,
  output logic [PORT_NUM-1:0][VC_NUM-1:0][CREDIT_SIZE-1:0] credit_count_o
);

  localparam logic [CREDIT_SIZE-1:0] CREDIT_FULL = CREDIT_SIZE'(BUFFER_SIZE);
  localparam logic [CREDIT_SIZE-1:0] CREDIT_ONE  = CREDIT_SIZE'(1);

  logic [CREDIT_SIZE-1:0]         credit  [PORT_NUM][VC_NUM];
  logic [VC_SIZE-1:0]             ptr_in  [PORT_NUM];
  logic [PORT_SIZE-1:0]           ptr_out [PORT_NUM];

  logic [PORT_NUM-1:0][VC_NUM-1:0] eligible;

  logic [PORT_NUM-1:0][VC_NUM-1:0] s1_grant;
  logic [VC_SIZE-1:0]              s1_idx [PORT_NUM];
  logic [PORT_NUM-1:0]             s1_valid;
  logic [PORT_SIZE-1:0]            s1_out [PORT_NUM];

  // s2_req / s2_grant are indexed [output][input]
  logic [PORT_NUM-1:0][PORT_NUM-1:0] s2_req;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] s2_grant;
  logic [PORT_SIZE-1:0]              s2_idx [PORT_NUM];
  logic [PORT_NUM-1:0]               s2_valid;

  logic [PORT_NUM-1:0]  in_granted;
  logic [VC_SIZE-1:0]   win_vc  [PORT_NUM];
  logic [VC_SIZE-1:0]   win_dvc [PORT_NUM];

`ifdef SA_PACKET_LOCK_EN
  logic [PORT_NUM-1:0]  win_tail;
  logic [PORT_NUM-1:0]  lock_valid;
  logic [PORT_SIZE-1:0] lock_ip [PORT_NUM];
  logic [VC_SIZE-1:0]   lock_vc [PORT_NUM];
`else
  logic unused_is_tail;
  assign unused_is_tail = ^is_tail_i;
`endif

  // A VC may compete only if it requests a real output port and the
  // downstream VC it targets still has buffer space. Credits are the
  // registered values, so a credit returned this cycle only helps next
  // cycle. With packet locking, a locked output is reserved for its owner
  // and the owning input may only offer the VC that holds the lock.
  always_comb begin
    for (int ip = 0; ip < PORT_NUM; ip++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        eligible[ip][v] = request_i[ip][v]
                          && (out_port_i[ip][v] < PORT_SIZE'(PORT_NUM))
                          && (credit[out_port_i[ip][v]][downstream_vc_i[ip][v]] != '0);
`ifdef SA_PACKET_LOCK_EN
        if ((out_port_i[ip][v] < PORT_SIZE'(PORT_NUM))
            && lock_valid[out_port_i[ip][v]]
            && ((lock_ip[out_port_i[ip][v]] != PORT_SIZE'(ip))
                || (lock_vc[out_port_i[ip][v]] != VC_SIZE'(v)))) begin
          eligible[ip][v] = 1'b0;
        end
        for (int op = 0; op < PORT_NUM; op++) begin
          if (lock_valid[op] && (lock_ip[op] == PORT_SIZE'(ip))
              && (lock_vc[op] != VC_SIZE'(v))) begin
            eligible[ip][v] = 1'b0;
          end
        end
`endif
      end
    end
  end

  // Stage 1: one VC arbiter per input, plus the output that VC asks for.
  for (genvar ip = 0; ip < PORT_NUM; ip++) begin : g_stage1
    rr_arbiter #(
      .N     (VC_NUM),
      .IDX_W (VC_SIZE)
    ) u_vc_arb (
      .request     (eligible[ip]),
      .ptr         (ptr_in[ip]),
      .grant       (s1_grant[ip]),
      .grant_idx   (s1_idx[ip]),
      .grant_valid (s1_valid[ip])
    );
    assign s1_out[ip] = out_port_i[ip][s1_idx[ip]];
  end

  // Each output sees a request from every input whose stage-1 candidate
  // targets it.
  always_comb begin
    for (int op = 0; op < PORT_NUM; op++) begin
      for (int ip = 0; ip < PORT_NUM; ip++) begin
        s2_req[op][ip] = s1_valid[ip] && (s1_out[ip] == PORT_SIZE'(op));
      end
    end
  end

  // Stage 2: one input arbiter per output.
  for (genvar op = 0; op < PORT_NUM; op++) begin : g_stage2
    rr_arbiter #(
      .N     (PORT_NUM),
      .IDX_W (PORT_SIZE)
    ) u_port_arb (
      .request     (s2_req[op]),
      .ptr         (ptr_out[op]),
      .grant       (s2_grant[op]),
      .grant_idx   (s2_idx[op]),
      .grant_valid (s2_valid[op])
    );
  end

  // An input is finally granted if any output picked it. Every candidate
  // targets exactly one output, so at most one bit per input can be set.
  // For each output, look up which VC of the winning input is crossing and
  // which downstream VC its credit is charged to.
  always_comb begin
    for (int ip = 0; ip < PORT_NUM; ip++) begin
      in_granted[ip] = 1'b0;
      for (int op = 0; op < PORT_NUM; op++) begin
        if (s2_grant[op][ip]) begin
          in_granted[ip] = 1'b1;
        end
      end
    end
    for (int op = 0; op < PORT_NUM; op++) begin
      win_vc[op]  = s1_idx[s2_idx[op]];
      win_dvc[op] = downstream_vc_i[s2_idx[op]][s1_idx[s2_idx[op]]];
`ifdef SA_PACKET_LOCK_EN
      win_tail[op] = is_tail_i[s2_idx[op]][s1_idx[s2_idx[op]]];
`endif
    end
  end

  // Registered allocation result. Inputs that won stage 1 but lost stage 2
  // get no pop strobe. The crossbar select only moves on a valid grant so
  // an idle output keeps its last setting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vc_grant_o     <= '0;
      input_vc_sel_o <= '0;
      valid_sel_o    <= '0;
    end else begin
      for (int ip = 0; ip < PORT_NUM; ip++) begin
        vc_grant_o[ip] <= in_granted[ip] ? s1_grant[ip] : '0;
      end
      for (int op = 0; op < PORT_NUM; op++) begin
        valid_sel_o[op] <= s2_valid[op];
        if (s2_valid[op]) begin
          input_vc_sel_o[op] <= s2_idx[op];
        end
      end
    end
  end

  // Round-robin pointers move past the winner only on a final grant, so a
  // stage-1 winner that loses stage 2 keeps its priority for the retry.
  // With packet locking the output pointer moves only when the packet ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ip = 0; ip < PORT_NUM; ip++) begin
        ptr_in[ip] <= '0;
      end
      for (int op = 0; op < PORT_NUM; op++) begin
        ptr_out[op] <= '0;
      end
    end else begin
      for (int ip = 0; ip < PORT_NUM; ip++) begin
        if (in_granted[ip]) begin
          ptr_in[ip] <= VC_SIZE'(wrap_next(int'(s1_idx[ip]), VC_NUM));
        end
      end
      for (int op = 0; op < PORT_NUM; op++) begin
`ifdef SA_PACKET_LOCK_EN
        if (s2_valid[op] && win_tail[op]) begin
`else
        if (s2_valid[op]) begin
`endif
          ptr_out[op] <= PORT_SIZE'(wrap_next(int'(s2_idx[op]), PORT_NUM));
        end
      end
    end
  end

  // Credit counters per output VC. A grant consumes one slot, a returned
  // credit frees one. Both on the same counter cancel out. A return on a
  // counter that is already full is dropped; a grant at zero cannot occur
  // because the VC would not have been eligible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int op = 0; op < PORT_NUM; op++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          credit[op][v] <= CREDIT_FULL;
        end
      end
    end else begin
      for (int op = 0; op < PORT_NUM; op++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          if ((s2_valid[op] && (win_dvc[op] == VC_SIZE'(v)))
              && !(credit_valid_i[op] && (credit_vc_i[op] == VC_SIZE'(v))
                   && (credit[op][v] != CREDIT_FULL))) begin
            credit[op][v] <= credit[op][v] - CREDIT_ONE;
          end else if (!(s2_valid[op] && (win_dvc[op] == VC_SIZE'(v)))
                       && (credit_valid_i[op] && (credit_vc_i[op] == VC_SIZE'(v))
                           && (credit[op][v] != CREDIT_FULL))) begin
            credit[op][v] <= credit[op][v] + CREDIT_ONE;
          end
        end
      end
    end
  end

`ifdef SA_PACKET_LOCK_EN
  // Packet locks: a granted non-tail flit claims the output for its
  // (input, VC) pair; granting that pair's tail flit frees it again. A
  // single-flit packet never takes the lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_valid <= '0;
      for (int op = 0; op < PORT_NUM; op++) begin
        lock_ip[op] <= '0;
        lock_vc[op] <= '0;
      end
    end else begin
      for (int op = 0; op < PORT_NUM; op++) begin
        if (s2_valid[op]) begin
          lock_valid[op] <= !win_tail[op];
          lock_ip[op]    <= s2_idx[op];
          lock_vc[op]    <= win_vc[op];
        end
      end
    end
  end
`endif

  for (genvar op = 0; op < PORT_NUM; op++) begin : g_credit_view
    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      assign credit_count_o[op][v] = credit[op][v];
    end
  end

endmodule

// File: tb/tb_switch_allocator_rr.sv
// -----------------------------------------------------------------------------
// tb_switch_allocator_rr
//   Scoreboard bench for switch_allocator_rr. Every driven cycle the
//   reference model works out the registered outputs that must appear after
//   the next clock edge and queues them; a monitor pops and compares after
//   each edge. Directed scenarios add a few fixed-value checks.
// -----------------------------------------------------------------------------
module tb_switch_allocator_rr;
  import noc_params::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [PORT_NUM-1:0][VC_NUM-1:0]                 request_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0]  out_port_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]    downstream_vc_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                 is_tail_i;
  logic [PORT_NUM-1:0]                             credit_valid_i;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]                credit_vc_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                 vc_grant_o;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0]              input_vc_sel_o;
  logic [PORT_NUM-1:0]                             valid_sel_o;
  logic [PORT_NUM-1:0][VC_NUM-1:0][CREDIT_SIZE-1:0] credit_count_o;

  always #5 clk = ~clk;

  switch_allocator_rr dut (
    .clk             (clk),
    .rst             (rst),
    .request_i       (request_i),
    .out_port_i      (out_port_i),
    .downstream_vc_i (downstream_vc_i),
    .is_tail_i       (is_tail_i),
    .credit_valid_i  (credit_valid_i),
    .credit_vc_i     (credit_vc_i),
    .vc_grant_o      (vc_grant_o),
    .input_vc_sel_o  (input_vc_sel_o),
    .valid_sel_o     (valid_sel_o),
    .credit_count_o  (credit_count_o)
  );

  typedef struct {
    logic [PORT_NUM-1:0][VC_NUM-1:0]                  grant;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0]               sel;
    logic [PORT_NUM-1:0]                              valid;
    logic [PORT_NUM-1:0][VC_NUM-1:0][CREDIT_SIZE-1:0] cred;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  int m_credit  [PORT_NUM][VC_NUM];
  int m_ptr_in  [PORT_NUM];
  int m_ptr_out [PORT_NUM];
  int m_sel     [PORT_NUM];
  bit m_lock_valid [PORT_NUM];
  int m_lock_ip    [PORT_NUM];
  int m_lock_vc    [PORT_NUM];

  logic [PORT_NUM-1:0][VC_NUM-1:0][CREDIT_SIZE-1:0] full_cred;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  task automatic model_reset();
    for (int op = 0; op < PORT_NUM; op++) begin
      for (int v = 0; v < VC_NUM; v++) m_credit[op][v] = BUFFER_SIZE;
      m_ptr_in[op]     = 0;
      m_ptr_out[op]    = 0;
      m_sel[op]        = 0;
      m_lock_valid[op] = 1'b0;
      m_lock_ip[op]    = 0;
      m_lock_vc[op]    = 0;
    end
  endtask

  function automatic bit model_eligible(input int ip, input int v);
    int op;
    if (!request_i[ip][v]) return 1'b0;
    op = int'(out_port_i[ip][v]);
    if (op >= PORT_NUM) return 1'b0;
    if (m_credit[op][int'(downstream_vc_i[ip][v])] == 0) return 1'b0;
`ifdef SA_PACKET_LOCK_EN
    if (m_lock_valid[op] && (m_lock_ip[op] != ip || m_lock_vc[op] != v)) return 1'b0;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (m_lock_valid[o] && m_lock_ip[o] == ip && m_lock_vc[o] != v) return 1'b0;
    end
`endif
    return 1'b1;
  endfunction

  // One allocation cycle of the reference model on the currently driven
  // inputs; queues the outputs expected after the coming clock edge.
  task automatic model_step();
    int   cand [PORT_NUM];
    int   newc [PORT_NUM][VC_NUM];
    int   v, i, win, cv;
    exp_t e;
    for (int ip = 0; ip < PORT_NUM; ip++) begin
      cand[ip] = -1;
      for (int k = 0; k < VC_NUM; k++) begin
        v = (m_ptr_in[ip] + k) % VC_NUM;
        if (cand[ip] < 0 && model_eligible(ip, v)) cand[ip] = v;
      end
    end
    for (int op = 0; op < PORT_NUM; op++) begin
      for (int vv = 0; vv < VC_NUM; vv++) newc[op][vv] = m_credit[op][vv];
      if (credit_valid_i[op]) begin
        cv = int'(credit_vc_i[op]);
        if (m_credit[op][cv] < BUFFER_SIZE) newc[op][cv] = newc[op][cv] + 1;
      end
    end
    e.grant = '0;
    e.valid = '0;
    for (int op = 0; op < PORT_NUM; op++) begin
      win = -1;
      for (int k = 0; k < PORT_NUM; k++) begin
        i = (m_ptr_out[op] + k) % PORT_NUM;
        if (win < 0 && cand[i] >= 0 && int'(out_port_i[i][cand[i]]) == op) win = i;
      end
      if (win >= 0) begin
        e.valid[op] = 1'b1;
        e.grant[win][cand[win]] = 1'b1;
        m_sel[op] = win;
        cv = int'(downstream_vc_i[win][cand[win]]);
        newc[op][cv] = newc[op][cv] - 1;
        m_ptr_in[win] = (cand[win] + 1) % VC_NUM;
`ifdef SA_PACKET_LOCK_EN
        if (is_tail_i[win][cand[win]]) begin
          m_lock_valid[op] = 1'b0;
          m_ptr_out[op] = (win + 1) % PORT_NUM;
        end else begin
          m_lock_valid[op] = 1'b1;
          m_lock_ip[op] = win;
          m_lock_vc[op] = cand[win];
        end
`else
        m_ptr_out[op] = (win + 1) % PORT_NUM;
`endif
      end
      e.sel[op] = PORT_SIZE'(m_sel[op]);
    end
    for (int op = 0; op < PORT_NUM; op++) begin
      for (int vv = 0; vv < VC_NUM; vv++) begin
        m_credit[op][vv] = newc[op][vv];
        e.cred[op][vv] = CREDIT_SIZE'(newc[op][vv]);
      end
    end
    exp_q.push_back(e);
  endtask

  // Called just after a falling edge with the inputs already set: queue the
  // expectation and advance to the next falling edge.
  task automatic applyStimulus();
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    request_i       = '0;
    out_port_i      = '0;
    downstream_vc_i = '0;
    is_tail_i       = '1;
    credit_valid_i  = '0;
    credit_vc_i     = '0;
  endtask

  task automatic randomize_inputs();
    for (int ip = 0; ip < PORT_NUM; ip++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        request_i[ip][v]       = ($urandom_range(0, 99) < 60);
        out_port_i[ip][v]      = PORT_SIZE'($urandom_range(0, PORT_NUM - 1));
        downstream_vc_i[ip][v] = VC_SIZE'($urandom_range(0, VC_NUM - 1));
        is_tail_i[ip][v]       = ($urandom_range(0, 2) == 0);
      end
      credit_valid_i[ip] = ($urandom_range(0, 99) < 35);
      credit_vc_i[ip]    = VC_SIZE'($urandom_range(0, VC_NUM - 1));
    end
  endtask

  // Monitor: after every rising edge compare the DUT against the oldest
  // queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("sb_vc_grant", vc_grant_o, e.grant);
      checkOutput("sb_valid_sel", valid_sel_o, e.valid);
      checkOutput("sb_input_vc_sel", input_vc_sel_o, e.sel);
      checkOutput("sb_credit_count", credit_count_o, e.cred);
    end
  end

  initial begin
    for (int op = 0; op < PORT_NUM; op++)
      for (int v = 0; v < VC_NUM; v++)
        full_cred[op][v] = CREDIT_SIZE'(BUFFER_SIZE);

    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    checkOutput("reset_vc_grant", vc_grant_o, '0);
    checkOutput("reset_valid_sel", valid_sel_o, '0);
    checkOutput("reset_input_vc_sel", input_vc_sel_o, '0);
    checkOutput("reset_credits", credit_count_o, full_cred);
    rst = 1'b0;

    // idle
    repeat (3) applyStimulus();
    checkOutput("idle_valid_sel", valid_sel_o, '0);
    checkOutput("idle_credits", credit_count_o, full_cred);

    // input 1 VC0 and input 3 VC1 contend for output 2
    request_i[1][0] = 1'b1; out_port_i[1][0] = PORT_SIZE'(2);
    request_i[3][1] = 1'b1; out_port_i[3][1] = PORT_SIZE'(2);
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkOutput("alt_sel_out2", input_vc_sel_o[2], (k % 2 == 0) ? 1 : 3);
      checkOutput("alt_valid_out2", valid_sel_o[2], 1);
    end
    checkOutput("alt_credit_out2", credit_count_o[2][0], BUFFER_SIZE - 4);

    // input 0 VC0 drains output 4 VC0, then a single credit comes back
    clear_inputs();
    request_i[0][0] = 1'b1; out_port_i[0][0] = PORT_SIZE'(4);
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      checkOutput("drain_valid_out4", valid_sel_o[4], (k < BUFFER_SIZE) ? 1 : 0);
    end
    checkOutput("drain_credit_zero", credit_count_o[4][0], 0);
    credit_valid_i[4] = 1'b1; credit_vc_i[4] = '0;
    applyStimulus();
    checkOutput("credit_not_same_cycle", valid_sel_o[4], 0);
    credit_valid_i[4] = 1'b0;
    applyStimulus();
    checkOutput("credit_grant_n_plus_2", valid_sel_o[4], 1);

    // grant and credit return on output 1 VC1 in the same cycle at count 5
    clear_inputs();
    request_i[4][0] = 1'b1; out_port_i[4][0] = PORT_SIZE'(1); downstream_vc_i[4][0] = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("credit_at_five", credit_count_o[1][1], 5);
    credit_valid_i[1] = 1'b1; credit_vc_i[1] = 1'b1;
    applyStimulus();
    checkOutput("credit_same_cycle_hold", credit_count_o[1][1], 5);

    // input 2 offers both VCs to different outputs
    clear_inputs();
    request_i[2][0] = 1'b1; out_port_i[2][0] = PORT_SIZE'(3);
    request_i[2][1] = 1'b1; out_port_i[2][1] = PORT_SIZE'(0); downstream_vc_i[2][1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkOutput("one_vc_per_input", vc_grant_o[2], (k % 2 == 0) ? 2'b01 : 2'b10);
    end

    // random traffic
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      applyStimulus();
    end

    // asynchronous reset in the middle of traffic
    randomize_inputs();
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_vc_grant", vc_grant_o, '0);
    checkOutput("midreset_valid_sel", valid_sel_o, '0);
    checkOutput("midreset_input_vc_sel", input_vc_sel_o, '0);
    checkOutput("midreset_credits", credit_count_o, full_cred);
    model_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    #1;
    checkOutput("after_reset_no_stale_grant", vc_grant_o, '0);
    checkOutput("after_reset_no_stale_valid", valid_sel_o, '0);

`ifdef SA_PACKET_LOCK_EN
    // input 1 sends a 3-flit packet to output 0 while input 4 competes
    for (int k = 0; k < 4; k++) begin
      request_i[1][0] = (k < 3); out_port_i[1][0] = '0; is_tail_i[1][0] = (k == 2);
      request_i[4][0] = 1'b1;    out_port_i[4][0] = '0; downstream_vc_i[4][0] = 1'b1;
      is_tail_i[4][0] = 1'b1;
      applyStimulus();
      checkOutput("lock_sel_out0", input_vc_sel_o[0], (k < 3) ? 1 : 4);
    end
    clear_inputs();
`endif

    for (int n = 0; n < 300; n++) begin
      randomize_inputs();
      applyStimulus();
    end
    clear_inputs();
    applyStimulus();

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
